dest_pipe_tracker: RTL
======================

// Module: dest_pipe_tracker
// PURPOSE
//  Producer side of the operand-forwarding/stall interface. Carries each issued
//  instruction's destination info (valid, rd, is_load, result) through the E, M and W stages.
//  Drives E_rd/M_rd/E_is_load/E_out/M_out to the hazard unit and the writeback port to the
//  regfile. Applies the hazard unit's stall, branch flush and memory-wait freeze.
//  Keeps saturating performance counters.
// PARAMETERS
//  DATA_W  32  datapath width
//  REG_W   5   register index width
//  CNT_W   32  perf counter width
// PORTS
//  clk         in   1       clock, single domain
//  reset       in   1       asynchronous, active-high
//  D_valid     in   1       decode holds an instruction to issue
//  D_rd        in   REG_W   its destination; 0 = no write
//  D_is_load   in   1       instruction is a load
//  D_ready     out  1       issue accepted this cycle
//  stall       in   1       load-use stall from hazard unit
//  flush       in   1       squash the instruction issuing from D
//  E_result    in   DATA_W  execute-stage ALU result (combinational)
//  mem_rdata   in   DATA_W  load data for the M-stage load
//  mem_ready   in   1       mem_rdata valid this cycle
//  E_rd        out  REG_W   E destination, 0 if E bubble
//  E_is_load   out  1       E holds a valid load
//  E_out       out  DATA_W  = E_result when E valid, else 0
//  M_rd        out  REG_W   M destination, 0 if M bubble
//  M_out       out  DATA_W  M alu_out; mem_rdata if M is a load
//  mem_stall   out  1       M load waiting on memory
//  W_we        out  1       regfile write enable
//  W_rd        out  REG_W   regfile write index
//  W_data      out  DATA_W  regfile write data
//  retired     out  CNT_W   count of W_we cycles
//  stall_cyc   out  CNT_W   cycles with stall=1 and mem_stall=0
//  mem_cyc     out  CNT_W   cycles with mem_stall=1
// BEHAVIOUR
//  Reset (async, any cycle): all stages invalid with rd=0 and data=0; all counters 0;
//   therefore W_we=0, E_rd=M_rd=0, E_is_load=0.
//  An in-flight load is discarded on reset. No writeback occurs for it.
//  Destination rd=0 is tracked as valid but never asserts W_we.
//  mem_stall = M.valid & M.is_load & ~mem_ready.
//  Priority per cycle: mem_stall > stall > flush > normal.
//  mem_stall case: E and M hold their contents. W loads a bubble. D_ready=0.
//  stall case: E loads a bubble. M<-E, W<-M. D_ready=0.
//  flush case: E loads a bubble; the D instruction is consumed and dropped, D_ready=1.
//   M<-E, W<-M.
//  normal case: E<-{D_valid,D_rd,D_is_load}. M<-E with data=E_result. W<-M.
//   W data is mem_rdata for a load, else alu_out. D_ready=1.
//  Latency: issue to W_we is exactly 3 cycles with no stalls.
//   Each mem_stall or stall cycle adds one cycle.
//  M_out for a load shows mem_rdata even while mem_ready=0. Consumers qualify it with mem_stall.
//  W_we = W.valid & (W_rd != 0). W registers update only on clock edges.
//  Counters saturate at all-ones and never wrap.
//  stall and flush are asserted together: stall wins, and D is not consumed.
// STRUCTURE
//  Package pipe_pkg holds:
//   - stage_t struct {valid, rd[REG_W], is_load, data[DATA_W]}
//   - the constant BUBBLE = '0
//   - the enum adv_t {ADV, HOLD, BUBBLE_IN}
//  Sub-module pipe_stage_reg holds one stage_t with async reset. Its cmd input is adv_t.
//  The tracker instantiates it three times (E, M, W) and adds the priority logic and counters.
// TESTING
//  Issue rd=3 with E_result=0x11, then rd=4 with 0x22, no stalls.
//   -> W_we at cycles 3 and 4 with {3,0x11} then {4,0x22}; retired=2.
//  Issue a load rd=5, then mem_ready=0 for 2 cycles, then mem_rdata=0xCAFE.
//   -> mem_stall=1 for 2 cycles with E/M held and D_ready=0.
//   -> W writes {5,0xCAFE} one cycle after ready; mem_cyc=2.
//  Load rd=2 in E with stall=1 for 1 cycle.
//   -> E_rd=0 next cycle, M_rd=2, D_ready=0 during the stall; stall_cyc=1.
//  flush with D_rd=7.
//   -> rd 7 never reaches W_we; the E bubble shows E_rd=0; D_ready=1.
//  Issue rd=0 with E_result=0x55.
//   -> E_rd=0, no W_we; retired unchanged.
//  Assert reset mid-load while mem_stall=1.
//   -> all outputs 0 immediately; no W_we after release; counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stage record, advance commands and helpers for the destination pipe
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_REG_W  = 5;

    typedef struct packed {
        logic                   valid;
        logic [PIPE_REG_W-1:0]  rd;
        logic                   is_load;
        logic [PIPE_DATA_W-1:0] data;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    typedef enum logic [1:0] {
        ADV       = 2'd0,
        HOLD      = 2'd1,
        BUBBLE_IN = 2'd2
    } adv_t;

    // An invalid slot is always stored as an all-zero bubble so rd/data read as 0.
    function automatic stage_t make_stage(
        input logic                   valid,
        input logic [PIPE_REG_W-1:0]  rd,
        input logic                   is_load,
        input logic [PIPE_DATA_W-1:0] data
    );
        stage_t s;
        s = BUBBLE;
        if (valid) begin
            s.valid   = 1'b1;
            s.rd      = rd;
            s.is_load = is_load;
            s.data    = data;
        end
        return s;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one pipeline stage record with advance/hold/bubble control
module pipe_stage_reg
    import pipe_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  adv_t   cmd,
    input  stage_t d,
    output stage_t q
);

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        stage_d = stage_q;
        case (cmd)
            ADV:       stage_d = d;
            HOLD:      stage_d = stage_q;
            BUBBLE_IN: stage_d = BUBBLE;
            default:   stage_d = BUBBLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/dest_pipe_tracker.sv
// rtl/dest_pipe_tracker.sv - carries issued destinations through E/M/W, applies
// memory freeze / load-use stall / flush, and keeps saturating perf counters
module dest_pipe_tracker
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int REG_W  = PIPE_REG_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              D_valid,
    input  logic [REG_W-1:0]  D_rd,
    input  logic              D_is_load,
    output logic              D_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] E_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [REG_W-1:0]  E_rd,
    output logic              E_is_load,
    output logic [DATA_W-1:0] E_out,
    output logic [REG_W-1:0]  M_rd,
    output logic [DATA_W-1:0] M_out,
    output logic              mem_stall,
    output logic              W_we,
    output logic [REG_W-1:0]  W_rd,
    output logic [DATA_W-1:0] W_data,
    output logic [CNT_W-1:0]  retired,
    output logic [CNT_W-1:0]  stall_cyc,
    output logic [CNT_W-1:0]  mem_cyc
);

    stage_t e_q, m_q, w_q;
    stage_t e_d, m_d, w_d;
    adv_t   e_cmd, m_cmd, w_cmd;

    logic              mem_stall_c;
    logic              d_ready_c;
    logic              w_we_c;
    logic [DATA_W-1:0] m_out_c;
    logic              unused_w_is_load;

    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
    logic [CNT_W-1:0] mem_cyc_q, mem_cyc_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != {CNT_W{1'b1}})) begin
            return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return cnt;
    endfunction

    assign mem_stall_c = m_q.valid & m_q.is_load & ~mem_ready;

    // A load in M exposes the memory bus directly; consumers qualify it with mem_stall.
    assign m_out_c = (m_q.valid & m_q.is_load) ? mem_rdata : m_q.data;

    assign w_we_c = w_q.valid & (w_q.rd != '0);

    // Priority: memory freeze, then load-use stall, then flush, then normal issue.
    always_comb begin
        e_cmd     = ADV;
        m_cmd     = ADV;
        w_cmd     = ADV;
        d_ready_c = 1'b1;
        if (mem_stall_c) begin
            e_cmd     = HOLD;
            m_cmd     = HOLD;
            w_cmd     = BUBBLE_IN;
            d_ready_c = 1'b0;
        end else if (stall) begin
            e_cmd     = BUBBLE_IN;
            d_ready_c = 1'b0;
        end else if (flush) begin
            e_cmd = BUBBLE_IN;
        end
    end

    always_comb begin
        e_d = make_stage(D_valid, D_rd, D_is_load, '0);
        m_d = make_stage(e_q.valid, e_q.rd, e_q.is_load, E_result);
        w_d = make_stage(m_q.valid, m_q.rd, m_q.is_load, m_out_c);
    end

    pipe_stage_reg u_e_stage (
        .clk   (clk),
        .reset (reset),
        .cmd   (e_cmd),
        .d     (e_d),
        .q     (e_q)
    );

    pipe_stage_reg u_m_stage (
        .clk   (clk),
        .reset (reset),
        .cmd   (m_cmd),
        .d     (m_d),
        .q     (m_q)
    );

    pipe_stage_reg u_w_stage (
        .clk   (clk),
        .reset (reset),
        .cmd   (w_cmd),
        .d     (w_d),
        .q     (w_q)
    );

    always_comb begin
        retired_d   = sat_inc(retired_q, w_we_c);
        stall_cyc_d = sat_inc(stall_cyc_q, stall & ~mem_stall_c);
        mem_cyc_d   = sat_inc(mem_cyc_q, mem_stall_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q   <= '0;
            stall_cyc_q <= '0;
            mem_cyc_q   <= '0;
        end else begin
            retired_q   <= retired_d;
            stall_cyc_q <= stall_cyc_d;
            mem_cyc_q   <= mem_cyc_d;
        end
    end

    // The load flag is already resolved into W data by the time a record reaches W.
    assign unused_w_is_load = w_q.is_load;

    assign D_ready   = d_ready_c;
    assign E_rd      = e_q.valid ? e_q.rd : '0;
    assign E_is_load = e_q.valid & e_q.is_load;
    assign E_out     = e_q.valid ? E_result : e_q.data;
    assign M_rd      = m_q.valid ? m_q.rd : '0;
    assign M_out     = m_out_c;
    assign mem_stall = mem_stall_c;
    assign W_we      = w_we_c;
    assign W_rd      = w_q.rd;
    assign W_data    = w_q.data;
    assign retired   = retired_q;
    assign stall_cyc = stall_cyc_q;
    assign mem_cyc   = mem_cyc_q;

endmodule
